// File: rtl/de_morgan_pkg.sv
// Shared types and constants for the De Morgan second-law (form a) cell.
package de_morgan_pkg;

  localparam int unsigned DEFAULT_CNT_W = 16;

  // Bit {a,b} holds NOR(a,b); only the 00 entry is 1.
  localparam logic [3:0] NOR2_TT = 4'b0001;

  typedef logic [1:0] ab_t;

endpackage

// File: rtl/de_morgan_nor2_core.sv
// Purely combinational core: NOR form and its De Morgan AND-of-inverses equivalent.
module de_morgan_nor2_core (
  input  logic a,
  input  logic b,
  output logic y_nor,
  output logic y_and
);

  assign y_nor = ~(a | b);
  assign y_and = ~a & ~b;

endmodule

// File: rtl/de_morgan2_a.sv
// NOR2 leaf cell with registered copies, sticky equivalence checker, input coverage
// and a saturating sample counter.
module de_morgan2_a
  import de_morgan_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             c,
  output logic             c_q,
  output logic             c_alt_q,
  output logic             err,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] cnt
);

  logic y_nor;
  logic y_and;
  logic valid;
  ab_t  ab;

  de_morgan_nor2_core u_core (
    .a     (a),
    .b     (b),
    .y_nor (y_nor),
    .y_and (y_and)
  );

  assign c  = y_nor;
  assign ab = {a, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= 1'b0;
      c_alt_q <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
      cov     <= '0;
      cnt     <= '0;
    end else begin
      c_q     <= y_nor;
      c_alt_q <= y_and;
      valid   <= 1'b1;
      if (clr) begin
        err <= 1'b0;
        cov <= '0;
        cnt <= '0;
      end else begin
        // Compares the registered pair from the previous edge; valid masks the first post-reset edge.
        err     <= err | (valid & (c_q ^ c_alt_q));
        cov[ab] <= 1'b1;
        if (cnt != '1)
          cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_de_morgan2_a.sv
// Directed self-checking bench for de_morgan2_a (default width plus a 2-bit counter instance).
module tb_de_morgan2_a;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a   = 1'b0;
  logic        b   = 1'b0;
  logic        clr = 1'b0;
  logic        c, c_q, c_alt_q, err;
  logic [3:0]  cov;
  logic [15:0] cnt;
  logic        c2, c_q2, c_alt_q2, err2;
  logic [3:0]  cov2;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  de_morgan2_a dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .c(c), .c_q(c_q), .c_alt_q(c_alt_q), .err(err), .cov(cov), .cnt(cnt)
  );

  de_morgan2_a #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .c(c2), .c_q(c_q2), .c_alt_q(c_alt_q2), .err(err2), .cov(cov2), .cnt(cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    a = 1'b0; b = 1'b0;
    rst = 1'b1;
    step();
    step();
    total++; if (c_q !== 1'b0)      begin bad++; $display("FAIL reset_c_q got=%b exp=0", c_q); end
    total++; if (c_alt_q !== 1'b0)  begin bad++; $display("FAIL reset_c_alt_q got=%b exp=0", c_alt_q); end
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (cov !== 4'b0000)   begin bad++; $display("FAIL reset_cov got=%b exp=0000", cov); end
    total++; if (cnt !== 16'd0)     begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    total++; if (c !== 1'b1)        begin bad++; $display("FAIL reset_c00 got=%b exp=1", c); end
    a = 1'b1; #1;
    total++; if (c !== 1'b0)        begin bad++; $display("FAIL reset_c10 got=%b exp=0", c); end
    a = 1'b0; b = 1'b1; #1;
    total++; if (c !== 1'b0)        begin bad++; $display("FAIL reset_c01 got=%b exp=0", c); end
    b = 1'b0; #1;
    total++; if (c !== 1'b1)        begin bad++; $display("FAIL reset_c00b got=%b exp=1", c); end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_cov [4];
    logic       exp_c   [4];
    exp_c   = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_cov = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    a = 1'b0; b = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #1;
      total++; if (c !== exp_c[i]) begin bad++; $display("FAIL sweep_c[%0d] got=%b exp=%b", i, c, exp_c[i]); end
      step();
      total++; if (c_q !== exp_c[i])     begin bad++; $display("FAIL sweep_c_q[%0d] got=%b exp=%b", i, c_q, exp_c[i]); end
      total++; if (c_alt_q !== exp_c[i]) begin bad++; $display("FAIL sweep_c_alt_q[%0d] got=%b exp=%b", i, c_alt_q, exp_c[i]); end
      total++; if (cov !== exp_cov[i])   begin bad++; $display("FAIL sweep_cov[%0d] got=%b exp=%b", i, cov, exp_cov[i]); end
      total++; if (cnt !== 16'(i + 1))   begin bad++; $display("FAIL sweep_cnt[%0d] got=%0d exp=%0d", i, cnt, i + 1); end
      total++; if (err !== 1'b0)         begin bad++; $display("FAIL sweep_err[%0d] got=%b exp=0", i, err); end
    end
  endtask

  task automatic test_hold11();
    a = 1'b1; b = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    total++; if (c !== 1'b0)      begin bad++; $display("FAIL hold11_c got=%b exp=0", c); end
    total++; if (c_q !== 1'b0)    begin bad++; $display("FAIL hold11_c_q got=%b exp=0", c_q); end
    total++; if (cov !== 4'b1000) begin bad++; $display("FAIL hold11_cov got=%b exp=1000", cov); end
    total++; if (cnt !== 16'd10)  begin bad++; $display("FAIL hold11_cnt got=%0d exp=10", cnt); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL hold11_err got=%b exp=0", err); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt2 [6];
    exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    a = 1'b0; b = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (cnt2 !== exp_cnt2[i]) begin bad++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, cnt2, exp_cnt2[i]); end
    end
    total++; if (cnt !== 16'd6) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=6", cnt); end
  endtask

  task automatic test_clr();
    a = 1'b0; b = 1'b0;
    do_reset();
    step();
    total++; if (c_q !== 1'b1) begin bad++; $display("FAIL clr_pre_c_q got=%b exp=1", c_q); end
    a = 1'b0; b = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (cov !== 4'b0000) begin bad++; $display("FAIL clr_cov got=%b exp=0000", cov); end
    total++; if (cnt !== 16'd0)   begin bad++; $display("FAIL clr_cnt got=%0d exp=0", cnt); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL clr_err got=%b exp=0", err); end
    total++; if (c_q !== 1'b0)    begin bad++; $display("FAIL clr_c_q got=%b exp=0", c_q); end
    step();
    total++; if (cov !== 4'b0010) begin bad++; $display("FAIL clr_next_cov got=%b exp=0010", cov); end
    total++; if (cnt !== 16'd1)   begin bad++; $display("FAIL clr_next_cnt got=%0d exp=1", cnt); end
    rst = 1'b1; clr = 1'b1;
    step();
    rst = 1'b0; clr = 1'b0;
    total++; if (cnt !== 16'd0)   begin bad++; $display("FAIL rst_over_clr_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_force();
    a = 1'b1; b = 1'b0;
    do_reset();
    step();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL force_pre_err got=%b exp=0", err); end
    force dut.c_alt_q = 1'b1;
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL force_err got=%b exp=1", err); end
    release dut.c_alt_q;
    step();
    step();
    total++; if (err !== 1'b1)  begin bad++; $display("FAIL force_sticky_err got=%b exp=1", err); end
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL force_other_err got=%b exp=0", err2); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL force_rst_err got=%b exp=0", err); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep();
    test_hold11();
    test_saturate();
    test_clr();
    test_force();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
